// File: rtl/pipeline_mem_arbiter_if.sv
// Bundle of requester-side and memory-side signals for the pipeline memory arbiter.
// The slave view is what the arbiter sees; the master view is what drives it.
// The pipeline stages and the physical memory port share one bundle.
interface pipeline_mem_arbiter_if;
  logic        if_read;
  logic [15:0] if_addr;
  logic [15:0] if_rdata;
  logic        if_resp;
  logic        d_read;
  logic        d_write;
  logic [15:0] d_addr;
  logic [15:0] d_wdata;
  logic [1:0]  d_wmask;
  logic [15:0] d_rdata;
  logic        d_resp;
  logic        mem_read;
  logic        mem_write;
  logic [15:0] mem_address;
  logic [15:0] mem_wdata;
  logic [1:0]  mem_byte_enable;
  logic [15:0] mem_rdata;
  logic        mem_resp;
  logic        ld_regs;
  logic        busy;

  modport slave (
    input  if_read, if_addr, d_read, d_write, d_addr, d_wdata, d_wmask,
           mem_rdata, mem_resp,
    output if_rdata, if_resp, d_rdata, d_resp, mem_read, mem_write,
           mem_address, mem_wdata, mem_byte_enable, ld_regs, busy
  );

  modport master (
    output if_read, if_addr, d_read, d_write, d_addr, d_wdata, d_wmask,
           mem_rdata, mem_resp,
    input  if_rdata, if_resp, d_rdata, d_resp, mem_read, mem_write,
           mem_address, mem_wdata, mem_byte_enable, ld_regs, busy
  );
endinterface

// File: rtl/pipeline_mem_arbiter.sv
// Shares one memory port between the fetch and mem stages; data side has fixed priority.
// Latency: port strobes one cycle after the grant, resp pulse one cycle after mem_resp.
// Backpressure: requests are held off until the port completes; ld_regs advances the pipe.
module pipeline_mem_arbiter (
  input  logic                   clk,
  input  logic                   rst_n,
  pipeline_mem_arbiter_if.slave  bus
);

  typedef enum logic [1:0] {IDLE = 2'd0, FETCH = 2'd1, DATA = 2'd2} state_t;

  state_t      r_state, w_state;
  logic        r_fetch_done, w_fetch_done;
  logic        r_data_done, w_data_done;
  logic        r_mem_read, w_mem_read;
  logic        r_mem_write, w_mem_write;
  logic [15:0] r_mem_address, w_mem_address;
  logic [15:0] r_mem_wdata, w_mem_wdata;
  logic [1:0]  r_mem_be, w_mem_be;
  logic [15:0] r_if_rdata, w_if_rdata;
  logic        r_if_resp, w_if_resp;
  logic [15:0] r_d_rdata, w_d_rdata;
  logic        r_d_resp, w_d_resp;
  logic        r_ld_regs, w_ld_regs;
  logic        r_busy, w_busy;

  logic        w_dreq, w_freq;

  // A stage that has already been served this pipeline step must not re-request.
  assign w_dreq = (bus.d_read | bus.d_write) & ~r_data_done;
  assign w_freq = bus.if_read & ~r_fetch_done;

  // Next-state and next-output logic; every output is registered from here.
  always_comb begin
    w_state       = r_state;
    w_fetch_done  = r_fetch_done;
    w_data_done   = r_data_done;
    w_mem_read    = r_mem_read;
    w_mem_write   = r_mem_write;
    w_mem_address = r_mem_address;
    w_mem_wdata   = r_mem_wdata;
    w_mem_be      = r_mem_be;
    w_if_rdata    = r_if_rdata;
    w_if_resp     = 1'b0;
    w_d_rdata     = r_d_rdata;
    w_d_resp      = 1'b0;
    w_ld_regs     = 1'b0;
    unique case (r_state)
      IDLE: begin
        if (w_dreq) begin
          w_state       = DATA;
          w_mem_address = bus.d_addr;
          w_mem_wdata   = bus.d_wdata;
          w_mem_be      = bus.d_wmask;
          // Read and write together is treated as a write.
          w_mem_write   = bus.d_write;
          w_mem_read    = ~bus.d_write;
        end else if (w_freq) begin
          w_state       = FETCH;
          w_mem_address = bus.if_addr;
          w_mem_read    = 1'b1;
          w_mem_write   = 1'b0;
          w_mem_be      = 2'b11;
        end else begin
          // Nothing outstanding: advance the pipeline and re-arm both requesters.
          w_ld_regs    = 1'b1;
          w_fetch_done = 1'b0;
          w_data_done  = 1'b0;
        end
      end
      FETCH: begin
        if (bus.mem_resp) begin
          w_state      = IDLE;
          w_if_rdata   = bus.mem_rdata;
          w_if_resp    = 1'b1;
          w_fetch_done = 1'b1;
          w_mem_read   = 1'b0;
        end
      end
      DATA: begin
        if (bus.mem_resp) begin
          w_state     = IDLE;
          if (!r_mem_write) w_d_rdata = bus.mem_rdata;
          w_d_resp    = 1'b1;
          w_data_done = 1'b1;
          w_mem_read  = 1'b0;
          w_mem_write = 1'b0;
        end
      end
      default: w_state = IDLE;
    endcase
    w_busy = (w_state != IDLE);
  end

  // State and output registers; reset abandons any in-flight transaction.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state       <= IDLE;
      r_fetch_done  <= 1'b0;
      r_data_done   <= 1'b0;
      r_mem_read    <= 1'b0;
      r_mem_write   <= 1'b0;
      r_mem_address <= 16'h0000;
      r_mem_wdata   <= 16'h0000;
      r_mem_be      <= 2'b11;
      r_if_rdata    <= 16'h0000;
      r_if_resp     <= 1'b0;
      r_d_rdata     <= 16'h0000;
      r_d_resp      <= 1'b0;
      r_ld_regs     <= 1'b0;
      r_busy        <= 1'b0;
    end else begin
      r_state       <= w_state;
      r_fetch_done  <= w_fetch_done;
      r_data_done   <= w_data_done;
      r_mem_read    <= w_mem_read;
      r_mem_write   <= w_mem_write;
      r_mem_address <= w_mem_address;
      r_mem_wdata   <= w_mem_wdata;
      r_mem_be      <= w_mem_be;
      r_if_rdata    <= w_if_rdata;
      r_if_resp     <= w_if_resp;
      r_d_rdata     <= w_d_rdata;
      r_d_resp      <= w_d_resp;
      r_ld_regs     <= w_ld_regs;
      r_busy        <= w_busy;
    end
  end

  assign bus.mem_read        = r_mem_read;
  assign bus.mem_write       = r_mem_write;
  assign bus.mem_address     = r_mem_address;
  assign bus.mem_wdata       = r_mem_wdata;
  assign bus.mem_byte_enable = r_mem_be;
  assign bus.if_rdata        = r_if_rdata;
  assign bus.if_resp         = r_if_resp;
  assign bus.d_rdata         = r_d_rdata;
  assign bus.d_resp          = r_d_resp;
  assign bus.ld_regs         = r_ld_regs;
  assign bus.busy            = r_busy;

endmodule

// File: tb/tb_pipeline_mem_arbiter.sv
// Testbench for pipeline_mem_arbiter: per-cycle vector table plus reset-mid-transaction sequence.
module tb_pipeline_mem_arbiter;

  typedef struct packed {
    logic        if_read;
    logic [15:0] if_addr;
    logic        d_read;
    logic        d_write;
    logic [15:0] d_addr;
    logic [15:0] d_wdata;
    logic [1:0]  d_wmask;
    logic        mem_resp;
    logic [15:0] mem_rdata;
  } in_t;

  typedef struct packed {
    logic        mem_read;
    logic        mem_write;
    logic [15:0] mem_address;
    logic [15:0] mem_wdata;
    logic [1:0]  mem_be;
    logic        if_resp;
    logic [15:0] if_rdata;
    logic        d_resp;
    logic [15:0] d_rdata;
    logic        ld_regs;
    logic        busy;
  } out_t;

  typedef struct packed {
    in_t  i;
    out_t o;
  } vec_t;

  logic clk = 1'b0;
  logic rst_n = 1'b1;
  int   n_checks = 0;
  int   n_errors = 0;
  vec_t vecs[$];

  always #5 clk = ~clk;

  pipeline_mem_arbiter_if bus_if ();

  pipeline_mem_arbiter dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus_if)
  );

  function automatic in_t mk_in(logic ir, logic [15:0] ia, logic dr, logic dw,
                                logic [15:0] da, logic [15:0] wd, logic [1:0] wm,
                                logic mr, logic [15:0] mrd);
    in_t v;
    v.if_read = ir; v.if_addr = ia; v.d_read = dr; v.d_write = dw;
    v.d_addr = da; v.d_wdata = wd; v.d_wmask = wm; v.mem_resp = mr; v.mem_rdata = mrd;
    return v;
  endfunction

  function automatic out_t mk_out(logic rd, logic wr, logic [15:0] a, logic [15:0] wd,
                                  logic [1:0] be, logic ir, logic [15:0] ird, logic dres,
                                  logic [15:0] drd, logic ld, logic bsy);
    out_t v;
    v.mem_read = rd; v.mem_write = wr; v.mem_address = a; v.mem_wdata = wd;
    v.mem_be = be; v.if_resp = ir; v.if_rdata = ird; v.d_resp = dres;
    v.d_rdata = drd; v.ld_regs = ld; v.busy = bsy;
    return v;
  endfunction

  task automatic add(input in_t i, input out_t o);
    vec_t v;
    v.i = i; v.o = o;
    vecs.push_back(v);
  endtask

  task automatic drive(input in_t v);
    bus_if.if_read   = v.if_read;
    bus_if.if_addr   = v.if_addr;
    bus_if.d_read    = v.d_read;
    bus_if.d_write   = v.d_write;
    bus_if.d_addr    = v.d_addr;
    bus_if.d_wdata   = v.d_wdata;
    bus_if.d_wmask   = v.d_wmask;
    bus_if.mem_resp  = v.mem_resp;
    bus_if.mem_rdata = v.mem_rdata;
  endtask

  task automatic check(input out_t exp, input string name);
    out_t act;
    act = mk_out(bus_if.mem_read, bus_if.mem_write, bus_if.mem_address, bus_if.mem_wdata,
                 bus_if.mem_byte_enable, bus_if.if_resp, bus_if.if_rdata, bus_if.d_resp,
                 bus_if.d_rdata, bus_if.ld_regs, bus_if.busy);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h required %h", name, act, exp);
    end
  endtask

  in_t  z;
  out_t rst_o;

  initial begin
    z     = mk_in(0, 16'h0, 0, 0, 16'h0, 16'h0, 2'b00, 0, 16'h0);
    rst_o = mk_out(0, 0, 16'h0, 16'h0, 2'b11, 0, 16'h0, 0, 16'h0, 0, 0);

    // Idle bus with a stray mem_resp: ld_regs every cycle, no resp pulse.
    add(z, rst_o);
    add(mk_in(0, 16'h0, 0, 0, 16'h0, 16'h0, 2'b00, 1, 16'hFFFF),
        mk_out(0, 0, 16'h0, 16'h0, 2'b11, 0, 16'h0, 0, 16'h0, 1, 0));
    for (int k = 0; k < 4; k++)
      add(z, mk_out(0, 0, 16'h0, 16'h0, 2'b11, 0, 16'h0, 0, 16'h0, 1, 0));

    // Fetch only, mem_resp at cycle 3.
    add(mk_in(1, 16'h0040, 0, 0, 16'h0, 16'h0, 2'b00, 0, 16'h0),
        mk_out(0, 0, 16'h0000, 16'h0, 2'b11, 0, 16'h0, 0, 16'h0, 1, 0));
    add(mk_in(1, 16'h0040, 0, 0, 16'h0, 16'h0, 2'b00, 0, 16'h0),
        mk_out(1, 0, 16'h0040, 16'h0, 2'b11, 0, 16'h0, 0, 16'h0, 0, 1));
    add(mk_in(1, 16'h0040, 0, 0, 16'h0, 16'h0, 2'b00, 0, 16'h0),
        mk_out(1, 0, 16'h0040, 16'h0, 2'b11, 0, 16'h0, 0, 16'h0, 0, 1));
    add(mk_in(1, 16'h0040, 0, 0, 16'h0, 16'h0, 2'b00, 1, 16'h1234),
        mk_out(1, 0, 16'h0040, 16'h0, 2'b11, 0, 16'h0, 0, 16'h0, 0, 1));
    add(mk_in(1, 16'h0040, 0, 0, 16'h0, 16'h0, 2'b00, 0, 16'h0),
        mk_out(0, 0, 16'h0040, 16'h0, 2'b11, 1, 16'h1234, 0, 16'h0, 0, 0));
    add(z, mk_out(0, 0, 16'h0040, 16'h0, 2'b11, 0, 16'h1234, 0, 16'h0, 1, 0));

    // Simultaneous fetch and data read, two-cycle memory latency each.
    add(mk_in(1, 16'h0042, 1, 0, 16'h3000, 16'h0, 2'b11, 0, 16'h0),
        mk_out(0, 0, 16'h0040, 16'h0, 2'b11, 0, 16'h1234, 0, 16'h0, 1, 0));
    add(mk_in(1, 16'h0042, 1, 0, 16'h3000, 16'h0, 2'b11, 0, 16'h0),
        mk_out(1, 0, 16'h3000, 16'h0, 2'b11, 0, 16'h1234, 0, 16'h0, 0, 1));
    add(mk_in(1, 16'h0042, 1, 0, 16'h3000, 16'h0, 2'b11, 1, 16'hABCD),
        mk_out(1, 0, 16'h3000, 16'h0, 2'b11, 0, 16'h1234, 0, 16'h0, 0, 1));
    add(mk_in(1, 16'h0042, 1, 0, 16'h3000, 16'h0, 2'b11, 0, 16'h0),
        mk_out(0, 0, 16'h3000, 16'h0, 2'b11, 0, 16'h1234, 1, 16'hABCD, 0, 0));
    add(mk_in(1, 16'h0042, 1, 0, 16'h3000, 16'h0, 2'b11, 0, 16'h0),
        mk_out(1, 0, 16'h0042, 16'h0, 2'b11, 0, 16'h1234, 0, 16'hABCD, 0, 1));
    add(mk_in(1, 16'h0042, 1, 0, 16'h3000, 16'h0, 2'b11, 1, 16'h5678),
        mk_out(1, 0, 16'h0042, 16'h0, 2'b11, 0, 16'h1234, 0, 16'hABCD, 0, 1));
    add(mk_in(1, 16'h0042, 1, 0, 16'h3000, 16'h0, 2'b11, 0, 16'h0),
        mk_out(0, 0, 16'h0042, 16'h0, 2'b11, 1, 16'h5678, 0, 16'hABCD, 0, 0));
    add(z, mk_out(0, 0, 16'h0042, 16'h0, 2'b11, 0, 16'h5678, 0, 16'hABCD, 1, 0));

    // Write; requester inputs change mid-transaction and must be ignored.
    add(mk_in(0, 16'h0, 0, 1, 16'h2000, 16'hBEEF, 2'b01, 0, 16'h0),
        mk_out(0, 0, 16'h0042, 16'h0, 2'b11, 0, 16'h5678, 0, 16'hABCD, 1, 0));
    add(mk_in(0, 16'h0, 0, 1, 16'h1111, 16'h0000, 2'b10, 0, 16'h0),
        mk_out(0, 1, 16'h2000, 16'hBEEF, 2'b01, 0, 16'h5678, 0, 16'hABCD, 0, 1));
    add(mk_in(0, 16'h0, 0, 1, 16'h1111, 16'h0000, 2'b10, 1, 16'h9999),
        mk_out(0, 1, 16'h2000, 16'hBEEF, 2'b01, 0, 16'h5678, 0, 16'hABCD, 0, 1));
    add(mk_in(0, 16'h0, 0, 1, 16'h1111, 16'h0000, 2'b10, 0, 16'h0),
        mk_out(0, 0, 16'h2000, 16'hBEEF, 2'b01, 0, 16'h5678, 1, 16'hABCD, 0, 0));
    add(z, mk_out(0, 0, 16'h2000, 16'hBEEF, 2'b01, 0, 16'h5678, 0, 16'hABCD, 1, 0));

    // Read and write together behave as a write.
    add(mk_in(0, 16'h0, 1, 1, 16'h2002, 16'h00FF, 2'b10, 0, 16'h0),
        mk_out(0, 0, 16'h2000, 16'hBEEF, 2'b01, 0, 16'h5678, 0, 16'hABCD, 1, 0));
    add(mk_in(0, 16'h0, 1, 1, 16'h2002, 16'h00FF, 2'b10, 0, 16'h0),
        mk_out(0, 1, 16'h2002, 16'h00FF, 2'b10, 0, 16'h5678, 0, 16'hABCD, 0, 1));
    add(mk_in(0, 16'h0, 1, 1, 16'h2002, 16'h00FF, 2'b10, 1, 16'h7777),
        mk_out(0, 1, 16'h2002, 16'h00FF, 2'b10, 0, 16'h5678, 0, 16'hABCD, 0, 1));
    add(z, mk_out(0, 0, 16'h2002, 16'h00FF, 2'b10, 0, 16'h5678, 1, 16'hABCD, 0, 0));
    add(z, mk_out(0, 0, 16'h2002, 16'h00FF, 2'b10, 0, 16'h5678, 0, 16'hABCD, 1, 0));

    drive(z);
    #1 rst_n = 1'b0;
    #3 check(rst_o, "reset_state");
    @(posedge clk);
    #1 rst_n = 1'b1;

    for (int k = 0; k < vecs.size(); k++) begin
      drive(vecs[k].i);
      check(vecs[k].o, $sformatf("vec%0d", k));
      @(posedge clk);
      #1;
    end

    // Reset in the middle of a DATA write: immediate reset values, no d_resp afterwards.
    drive(mk_in(0, 16'h0, 0, 1, 16'h3333, 16'h1111, 2'b11, 0, 16'h0));
    @(posedge clk);
    #1 check(mk_out(0, 1, 16'h3333, 16'h1111, 2'b11, 0, 16'h5678, 0, 16'hABCD, 0, 1),
             "mid_data_granted");
    #2 rst_n = 1'b0;
    #1 check(rst_o, "async_reset_mid_data");
    drive(mk_in(0, 16'h0, 0, 0, 16'h0, 16'h0, 2'b00, 1, 16'h4444));
    @(posedge clk);
    #1 check(rst_o, "held_in_reset");
    #3 rst_n = 1'b1;
    @(posedge clk);
    #1 check(mk_out(0, 0, 16'h0, 16'h0, 2'b11, 0, 16'h0, 0, 16'h0, 1, 0), "after_release_1");
    drive(z);
    @(posedge clk);
    #1 check(mk_out(0, 0, 16'h0, 16'h0, 2'b11, 0, 16'h0, 0, 16'h0, 1, 0), "after_release_2");

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule

// File: doc/pipeline_mem_arbiter.md
PIPELINE_MEM_ARBITER -- requirements
Module: pipeline_mem_arbiter

Interface
REQ-001 SHALL use one clock and an asynchronous, active-low reset: clk and rst_n.
REQ-002 Ports SHALL be (name direction width meaning):
- clk  in  1  rising-edge clock
- rst_n  in  1  asynchronous active-low reset
- if_read  in  1  fetch-stage read request
- if_addr  in  16  fetch address
- if_rdata  out  16  fetch read data
- if_resp  out  1  fetch done pulse
- d_read  in  1  mem-stage read request
- d_write  in  1  mem-stage write request
- d_addr  in  16  data address
- d_wdata  in  16  write data
- d_wmask  in  2  write byte enables
- d_rdata  out  16  data read data
- d_resp  out  1  data done pulse
- mem_read  out  1  physical port read
- mem_write  out  1  physical port write
- mem_address  out  16  physical port address
- mem_wdata  out  16  physical port write data
- mem_byte_enable  out  2  physical port byte enables
- mem_rdata  in  16  physical port read data
- mem_resp  in  1  physical port completion
- ld_regs  out  1  pipeline-register advance strobe
- busy  out  1  transaction in flight

Function
REQ-003 FSM states SHALL be IDLE, FETCH and DATA; all outputs SHALL be registered.
REQ-004 Request terms: dreq = (d_read|d_write) & !data_done; freq = if_read & !fetch_done.
REQ-005 In IDLE, dreq SHALL go to DATA, else freq SHALL go to FETCH, else stay in IDLE (data has fixed priority).
REQ-006 On entering FETCH: latch if_addr into mem_address; mem_read=1, mem_write=0, mem_byte_enable=2'b11.
REQ-007 On entering DATA: latch d_addr, d_wdata and d_wmask; set mem_write=d_write and mem_read=!d_write (a simultaneous read and write is a write).
REQ-008 mem_address, mem_wdata, mem_byte_enable, mem_read and mem_write SHALL hold stable until the cycle mem_resp is sampled high; requester inputs are ignored while in FETCH or DATA.
REQ-009 On mem_resp in FETCH, the next cycle SHALL have: if_rdata=mem_rdata, if_resp=1 for one cycle, fetch_done=1, mem_read=0, state IDLE.
REQ-010 On mem_resp in DATA, the next cycle SHALL have: d_rdata=mem_rdata (reads only; unchanged on writes), d_resp=1 for one cycle, data_done=1, mem_read=mem_write=0, state IDLE.
REQ-011 mem_resp SHALL be ignored in IDLE.
REQ-012 ld_regs SHALL be asserted for exactly one cycle, the cycle after an IDLE cycle in which !freq & !dreq and no transaction starts; the same edge SHALL clear fetch_done and data_done.
REQ-013 With no requests at all, ld_regs SHALL be 1 every cycle.
REQ-014 Minimum handshake: if the request is seen in IDLE at cycle 0, mem_read/mem_write rise at cycle 1; with mem_resp at cycle k, resp pulses at k+1 and ld_regs at k+2 when no other request is pending.
REQ-015 busy SHALL be 1 exactly when the state is FETCH or DATA.
REQ-016 Both requesters active together SHALL give: full DATA transaction, then full FETCH transaction, then a single ld_regs; the memory port SHALL never carry two transactions at once.

Reset
REQ-017 rst_n low SHALL immediately force state IDLE, both done flags 0, and outputs mem_read=0, mem_write=0, mem_address=0, mem_wdata=0, mem_byte_enable=2'b11, if_rdata=0, d_rdata=0, if_resp=0, d_resp=0, ld_regs=0, busy=0.
REQ-018 Reset during FETCH or DATA SHALL abandon the transaction with no resp pulse; after release, mem_resp is ignored until a new grant.

Verification
REQ-019 Fetch only: if_read=1, if_addr=16'h0040, mem_resp one cycle at cycle 3 with mem_rdata=16'h1234 -> mem_read at cycles 1..3, if_resp and if_rdata=16'h1234 at cycle 4, ld_regs at cycle 5.
REQ-020 Simultaneous requests: if_read=1 (16'h0042) and d_read=1 (16'h3000), 2-cycle memory latency -> port serves 16'h3000 first and 16'h0042 second, d_resp before if_resp, one ld_regs after both.
REQ-021 Write: d_write=1, d_addr=16'h2000, d_wdata=16'hBEEF, d_wmask=2'b01 -> mem_write=1 with those values held stable until mem_resp; d_resp pulses; d_rdata unchanged.
REQ-022 Read and write together: d_read=d_write=1 -> mem_write=1 and mem_read=0 for the whole transaction.
REQ-023 Idle bus: all requests 0 for 5 cycles -> ld_regs=1 each cycle and busy=0; a stray mem_resp causes no resp pulse.
REQ-024 Reset mid-DATA: rst_n low while mem_write=1 -> all outputs at reset values in the same cycle; no d_resp after release.
